// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side signal bundle for hazard_ctrl (perf ports under HAZARD_PERF_CNT_EN)
interface hazard_ctrl_if
`ifdef HAZARD_PERF_CNT_EN
    #(parameter int PERF_W = 32)
`endif
    ;

    logic [4:0] Rs1_D;
    logic [4:0] Rs2_D;
    logic [4:0] Rs1_E;
    logic [4:0] Rs2_E;
    logic [4:0] Rd_E;
    logic [4:0] Rd_M;
    logic [4:0] Rd_W;
    logic       RegWrite_M;
    logic       RegWrite_W;
    logic [1:0] ResultSrc_E;
    logic       PCSrc_E;
    logic       MemReq_M;
    logic       MemReady_M;
    logic       ErrClr;

    logic       Stall_F;
    logic       Stall_D;
    logic       Stall_E;
    logic       Stall_M;
    logic       Flush_D;
    logic       Flush_E;
    logic       Flush_W;
    logic [1:0] ForwardA_E;
    logic [1:0] ForwardB_E;
    logic       MemErr;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] LuStallCnt;
    logic [PERF_W-1:0] MemStallCnt;
    logic [PERF_W-1:0] FlushCnt;
`endif

    // Pipeline side: drives register ids and status, receives control.
    modport master (
        output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
        output RegWrite_M, RegWrite_W, ResultSrc_E, PCSrc_E,
        output MemReq_M, MemReady_M, ErrClr,
        input  Stall_F, Stall_D, Stall_E, Stall_M,
        input  Flush_D, Flush_E, Flush_W,
        input  ForwardA_E, ForwardB_E, MemErr
`ifdef HAZARD_PERF_CNT_EN
        , input LuStallCnt, MemStallCnt, FlushCnt
`endif
    );

    // Hazard controller side.
    modport slave (
        input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
        input  RegWrite_M, RegWrite_W, ResultSrc_E, PCSrc_E,
        input  MemReq_M, MemReady_M, ErrClr,
        output Stall_F, Stall_D, Stall_E, Stall_M,
        output Flush_D, Flush_E, Flush_W,
        output ForwardA_E, ForwardB_E, MemErr
`ifdef HAZARD_PERF_CNT_EN
        , output LuStallCnt, MemStallCnt, FlushCnt
`endif
    );

endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline hazard controller with memory-wait FSM (perf counters under HAZARD_PERF_CNT_EN)
module hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
`ifdef HAZARD_PERF_CNT_EN
    , parameter int PERF_W = 32
`endif
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t          state;
    logic [TO_W-1:0] wait_cnt;
    logic            mem_err;

    logic            lu;
    logic            mw;
    logic            run_rules;
    logic            freeze;
    logic            branch_flush;
    logic            lu_stall;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;

    // Operand forwarding: the younger result in M wins over W; x0 is never forwarded.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (hif.RegWrite_M && hif.Rd_M != 5'd0 && hif.Rd_M == hif.Rs1_E)
            fwd_a = 2'b10;
        else if (hif.RegWrite_W && hif.Rd_W != 5'd0 && hif.Rd_W == hif.Rs1_E)
            fwd_a = 2'b01;
        if (hif.RegWrite_M && hif.Rd_M != 5'd0 && hif.Rd_M == hif.Rs2_E)
            fwd_b = 2'b10;
        else if (hif.RegWrite_W && hif.Rd_W != 5'd0 && hif.Rd_W == hif.Rs2_E)
            fwd_b = 2'b01;
    end

    // Mealy stall/flush decode; a completing wait falls straight through to the RUN rules.
    always_comb begin
        lu = (hif.ResultSrc_E == 2'b01) && (hif.Rd_E != 5'd0) &&
             ((hif.Rd_E == hif.Rs1_D) || (hif.Rd_E == hif.Rs2_D));
        mw = hif.MemReq_M && !hif.MemReady_M;
        run_rules    = (state == RUN) || ((state == MEM_WAIT) && hif.MemReady_M);
        freeze       = 1'b0;
        branch_flush = 1'b0;
        lu_stall     = 1'b0;
        if (run_rules) begin
            if (mw)
                freeze = 1'b1;
            else if (hif.PCSrc_E)
                branch_flush = 1'b1;
            else if (lu)
                lu_stall = 1'b1;
        end else begin
            freeze = 1'b1;
        end
    end

    assign hif.Stall_F    = freeze | lu_stall;
    assign hif.Stall_D    = freeze | lu_stall;
    assign hif.Stall_E    = freeze;
    assign hif.Stall_M    = freeze;
    assign hif.Flush_D    = branch_flush;
    assign hif.Flush_E    = branch_flush | lu_stall;
    assign hif.Flush_W    = freeze;
    assign hif.ForwardA_E = fwd_a;
    assign hif.ForwardB_E = fwd_b;
    assign hif.MemErr     = mem_err;

    // Memory-wait FSM with timeout watchdog and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mw) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= TO_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (hif.MemReady_M) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
                        state   <= ERR;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                ERR: begin
                    if (hif.ErrClr) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                        mem_err  <= 1'b0;
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] lu_cnt;
    logic [PERF_W-1:0] mem_cnt;
    logic [PERF_W-1:0] flush_cnt;

    // Saturating event counters for load-use stalls, memory-stall cycles and branch flushes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lu_cnt    <= '0;
            mem_cnt   <= '0;
            flush_cnt <= '0;
        end else begin
            if (lu_stall && lu_cnt != '1)
                lu_cnt <= lu_cnt + PERF_W'(1);
            if (freeze && mem_cnt != '1)
                mem_cnt <= mem_cnt + PERF_W'(1);
            if (branch_flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + PERF_W'(1);
        end
    end

    assign hif.LuStallCnt  = lu_cnt;
    assign hif.MemStallCnt = mem_cnt;
    assign hif.FlushCnt    = flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl (TIMEOUT = 4)
module tb_hazard_ctrl;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    hazard_ctrl_if hif ();

    hazard_ctrl #(.TIMEOUT(4), .TO_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hif.Rs1_D = 0; hif.Rs2_D = 0; hif.Rs1_E = 0; hif.Rs2_E = 0;
        hif.Rd_E = 0; hif.Rd_M = 0; hif.Rd_W = 0;
        hif.RegWrite_M = 0; hif.RegWrite_W = 0; hif.ResultSrc_E = 2'b00;
        hif.PCSrc_E = 0; hif.MemReq_M = 0; hif.MemReady_M = 0; hif.ErrClr = 0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        clear_inputs();
        #1;
        check("rst_memerr", 32'(hif.MemErr), 0);
        check("rst_stall_m", 32'(hif.Stall_M), 0);
        check("rst_fwd_a", 32'(hif.ForwardA_E), 0);
        tick();
        reset = 1'b0;

        // forwarding
        hif.Rs1_E = 5; hif.Rs2_E = 6; hif.Rd_M = 5; hif.RegWrite_M = 1; hif.Rd_W = 5; hif.RegWrite_W = 1;
        #1;
        check("fwd_a_m", 32'(hif.ForwardA_E), 2);
        check("fwd_b_none", 32'(hif.ForwardB_E), 0);
        hif.RegWrite_M = 0; hif.Rs2_E = 5;
        #1;
        check("fwd_a_w", 32'(hif.ForwardA_E), 1);
        check("fwd_b_w", 32'(hif.ForwardB_E), 1);
        hif.Rs1_E = 0; hif.Rd_M = 0; hif.Rd_W = 0; hif.RegWrite_M = 1;
        #1;
        check("fwd_a_x0", 32'(hif.ForwardA_E), 0);
        clear_inputs();

        // load-use stall, one cycle
        tick();
        hif.ResultSrc_E = 2'b01; hif.Rd_E = 7; hif.Rs2_D = 7;
        #1;
        check("lu_stall_f", 32'(hif.Stall_F), 1);
        check("lu_stall_d", 32'(hif.Stall_D), 1);
        check("lu_flush_e", 32'(hif.Flush_E), 1);
        check("lu_stall_m", 32'(hif.Stall_M), 0);
        check("lu_flush_d", 32'(hif.Flush_D), 0);
        tick();
        hif.ResultSrc_E = 2'b00; hif.Rd_E = 0;
        #1;
        check("lu_bubble_stall_f", 32'(hif.Stall_F), 0);
        check("lu_bubble_flush_e", 32'(hif.Flush_E), 0);
        hif.ResultSrc_E = 2'b01; hif.Rd_E = 0; hif.Rs2_D = 0;
        #1;
        check("lu_rd0_stall_f", 32'(hif.Stall_F), 0);
        hif.ResultSrc_E = 2'b10; hif.Rd_E = 7; hif.Rs2_D = 7;
        #1;
        check("nonload_stall_f", 32'(hif.Stall_F), 0);

        // branch overrides load-use
        hif.ResultSrc_E = 2'b01; hif.PCSrc_E = 1;
        #1;
        check("br_flush_d", 32'(hif.Flush_D), 1);
        check("br_flush_e", 32'(hif.Flush_E), 1);
        check("br_stall_f", 32'(hif.Stall_F), 0);
        tick();
        clear_inputs();

        // memory wait, 3 stalled cycles then release
        hif.MemReq_M = 1;
        #1;
        check("mw0_stall_m", 32'(hif.Stall_M), 1);
        check("mw0_flush_w", 32'(hif.Flush_W), 1);
        check("mw0_stall_f", 32'(hif.Stall_F), 1);
        tick();
        check("mw1_stall_m", 32'(hif.Stall_M), 1);
        hif.PCSrc_E = 1;
        #1;
        check("mw1_branch_ignored", 32'(hif.Flush_D), 0);
        tick();
        check("mw2_stall_m", 32'(hif.Stall_M), 1);
        check("mw2_flush_w", 32'(hif.Flush_W), 1);
        tick();
        hif.MemReady_M = 1;
        #1;
        check("mw_rel_stall_m", 32'(hif.Stall_M), 0);
        check("mw_rel_flush_w", 32'(hif.Flush_W), 0);
        check("mw_rel_branch", 32'(hif.Flush_D), 1);
        check("mw_rel_memerr", 32'(hif.MemErr), 0);
        tick();
        clear_inputs();
        #1;
        check("mw_after_stall_m", 32'(hif.Stall_M), 0);
        check("mw_after_memerr", 32'(hif.MemErr), 0);

        // timeout into ERR, sticky, cleared by ErrClr
        hif.MemReq_M = 1;
        tick();
        check("to1_memerr", 32'(hif.MemErr), 0);
        hif.ErrClr = 1;
        tick();
        hif.ErrClr = 0;
        check("to2_memerr", 32'(hif.MemErr), 0);
        check("to2_stall_m", 32'(hif.Stall_M), 1);
        tick();
        check("to3_memerr", 32'(hif.MemErr), 0);
        tick();
        check("to4_memerr", 32'(hif.MemErr), 1);
        hif.MemReq_M = 0;
        #1;
        check("err_stall_f", 32'(hif.Stall_F), 1);
        check("err_flush_w", 32'(hif.Flush_W), 1);
        tick();
        check("err_sticky", 32'(hif.MemErr), 1);
        hif.ErrClr = 1;
        tick();
        hif.ErrClr = 0;
        #1;
        check("clr_memerr", 32'(hif.MemErr), 0);
        check("clr_stall_m", 32'(hif.Stall_M), 0);

        // reset in cycle 2 of MEM_WAIT
        hif.MemReq_M = 1;
        tick();
        tick();
        hif.MemReq_M = 0;
        #1;
        check("rmw_frozen", 32'(hif.Stall_M), 1);
        reset = 1'b1;
        #1;
        check("rmw_async_stall_m", 32'(hif.Stall_M), 0);
        check("rmw_async_stall_f", 32'(hif.Stall_F), 0);
        check("rmw_async_memerr", 32'(hif.MemErr), 0);
        tick();
        reset = 1'b0;
        hif.MemReq_M = 1;
        #1;
        check("rmw_restart_stall", 32'(hif.Stall_M), 1);
        tick();
        tick();
        tick();
        check("rmw_cnt3_memerr", 32'(hif.MemErr), 0);
        tick();
        check("rmw_cnt4_memerr", 32'(hif.MemErr), 1);
        hif.MemReq_M = 0;
        hif.ErrClr = 1;
        tick();
        hif.ErrClr = 0;
        check("rmw_clr_memerr", 32'(hif.MemErr), 0);

`ifdef HAZARD_PERF_CNT_EN
        // perf counters: 2 load-use, 3 memory-stall cycles, 1 branch
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_inputs();
        check("perf_rst_lu", hif.LuStallCnt, 0);
        hif.ResultSrc_E = 2'b01; hif.Rd_E = 3; hif.Rs1_D = 3;
        tick();
        tick();
        clear_inputs();
        hif.MemReq_M = 1;
        tick();
        tick();
        tick();
        hif.MemReady_M = 1;
        tick();
        clear_inputs();
        hif.PCSrc_E = 1;
        tick();
        clear_inputs();
        tick();
        check("perf_lu", hif.LuStallCnt, 2);
        check("perf_mem", hif.MemStallCnt, 3);
        check("perf_flush", hif.FlushCnt, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard controller for the 5-stage RISC-V pipeline; generates stall/flush enables for the IF/ID, ID/EX, EX/MEM and MEM/WB registers and forwarding selects for the EX-stage ALU operands.
- Adds a registered FSM that freezes the pipeline while a multi-cycle data-memory access in M is outstanding, with a timeout watchdog and a sticky error.

Parameters:
- TIMEOUT, 16, maximum MEM_WAIT cycles before declaring a memory error (range 2..2^TO_W-1).
- TO_W, 5, width of the wait counter.
- PERF_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Rs1_D, Rs2_D  in  5  source registers of the instruction in D.
- Rs1_E, Rs2_E, Rd_E  in  5  source and destination registers of the instruction in E.
- Rd_M, Rd_W  in  5  destination registers in M and W.
- RegWrite_M, RegWrite_W  in  1  register-write enables in M and W.
- ResultSrc_E  in  2  result select in E; 2'b01 means the instruction is a load.
- PCSrc_E  in  1  taken branch or jump resolved in E.
- MemReq_M  in  1  data-memory access active in M.
- MemReady_M  in  1  data memory completes the access this cycle.
- ErrClr  in  1  clears the error state.
- Stall_F, Stall_D, Stall_E, Stall_M  out  1  hold the PC and the IF/ID, ID/EX and EX/MEM registers.
- Flush_D, Flush_E, Flush_W  out  1  insert a bubble into IF/ID, ID/EX or MEM/WB.
- ForwardA_E, ForwardB_E  out  2  operand select: 00 = register file, 01 = W result, 10 = M ALU result.
- MemErr  out  1  sticky memory-timeout error.

Behaviour:
- Forwarding (combinational, all states):
  - ForwardA_E = 10 if RegWrite_M and Rd_M != 0 and Rd_M == Rs1_E.
  - Otherwise 01 if RegWrite_W and Rd_W != 0 and Rd_W == Rs1_E.
  - Otherwise 00.
  - M has priority over W. ForwardB_E uses the same rules with Rs2_E.
- FSM states, 2-bit register: RUN, MEM_WAIT, ERR. All stall/flush outputs are Mealy (state plus current inputs).
- RUN:
  - lu = (ResultSrc_E == 01) and Rd_E != 0 and (Rd_E == Rs1_D or Rd_E == Rs2_D).
  - mw = MemReq_M and not MemReady_M.
  - If mw: Stall_F = Stall_D = Stall_E = Stall_M = 1, Flush_W = 1, all other flushes 0. Next state is MEM_WAIT and the wait counter is loaded with 1.
  - Else if PCSrc_E: Flush_D = Flush_E = 1. The branch overrides lu: no stall.
  - Else if lu: Stall_F = Stall_D = 1, Flush_E = 1.
  - Otherwise all stall/flush outputs are 0.
- MEM_WAIT:
  - If MemReady_M: all stalls are released in the same cycle, and the branch/load-use rules of RUN are evaluated normally. Next state is RUN and the counter is cleared.
  - Else if counter == TIMEOUT-1: next state is ERR and MemErr is set.
  - Otherwise: counter increments; all four stalls and Flush_W stay 1; lu and PCSrc_E are ignored. E is frozen, so PCSrc_E is re-seen on release.
- ERR:
  - All four stalls and Flush_W are 1; MemErr = 1.
  - ErrClr = 1 returns to RUN next cycle and clears MemErr and the counter.
  - ErrClr has no effect in RUN or MEM_WAIT.
- Reset (asynchronous, any state, including mid-wait):
  - State = RUN, counter = 0, MemErr = 0.
  - Outputs immediately follow the RUN equations.
- MemReady_M without MemReq_M is ignored.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds output ports LuStallCnt, MemStallCnt and FlushCnt, each PERF_W bits wide.
  - LuStallCnt increments on each load-use stall cycle.
  - MemStallCnt increments on each cycle Stall_M = 1.
  - FlushCnt increments on each cycle a branch flush is asserted.
- Counters saturate at all-ones and reset to 0.
- When not defined, none of these ports or registers exist, and all other behaviour is identical.

Test Plan:
- Forwarding:
  - Rs1_E = 5, Rd_M = 5, RegWrite_M = 1, Rd_W = 5, RegWrite_W = 1 -> ForwardA_E = 10.
  - Drop RegWrite_M -> ForwardA_E = 01.
  - Rs1_E = 0 -> ForwardA_E = 00.
- Load-use: ResultSrc_E = 01, Rd_E = 7, Rs2_D = 7 -> Stall_F = Stall_D = Flush_E = 1 for exactly one cycle. Repeat with PCSrc_E = 1 -> Flush_D = Flush_E = 1 and Stall_F = 0.
- Memory wait: MemReq_M = 1 with MemReady_M low for 3 cycles, then high -> Stall_M = 1 and Flush_W = 1 for 3 cycles, then released; MemErr stays 0.
- Timeout with TIMEOUT = 4: MemReady_M held low -> state reaches ERR after 4 stalled cycles and MemErr = 1, sticky. ErrClr pulse -> RUN next cycle, MemErr = 0.
- Reset mid-wait: assert reset in cycle 2 of MEM_WAIT -> stalls drop asynchronously and MemErr = 0; the next MemReq_M restarts the counter from 1.
- HAZARD_PERF_CNT_EN: 2 load-use stalls, 3 memory-stall cycles and 1 branch -> counters read 2, 3 and 1.
